div_request_sequencer: RTL
==========================

# div_request_sequencer

Front-end sequencer for the 32-bit unsigned divider `CompDivider`. It buffers divide requests in a small FIFO, drives the divider's load/run handshake (`Rst` pulse, idle gap, `Run` held until the rising edge of `Rdy`), and returns tagged quotient/remainder results on a valid/ready port. It also short-circuits divide-by-zero and bounds every divider operation with a timeout.

## Interface
- `DEPTH`, 4: request FIFO entries; power of 2, at least 2.
- `TAG_W`, 4: request tag width.
- `TIMEOUT`, 64: maximum `RUN` cycles before abort; at least 2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `ReqValid` in 1 / `ReqReady` out 1: request handshake.
- `ReqDvnd` in 32 / `ReqDvsr` in 32 / `ReqTag` in TAG_W: request payload.
- `RspValid` out 1 / `RspReady` in 1: response handshake.
- `RspQ` out 32 / `RspR` out 32 / `RspTag` out TAG_W: response payload.
- `RspDivZero` out 1 / `RspTimeout` out 1: response status flags.
- `DivDvnd` out 32 / `DivDvsr` out 32 / `DivRun` out 1 / `DivRst` out 1: connect to the divider's `Dvnd`, `Dvsr`, `Run` and `Rst`.
- `DivQ` in 32 / `DivR` in 32 / `DivRdy` in 1: connect to the divider's `Q`, `R` and `Rdy`.
- `Busy` out 1: FSM is not in `IDLE`.
- `ReqCount` out log2(DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO.** A push happens when `ReqValid & ReqReady`. `ReqReady = ~full & ~Rst`.
  - A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
  - A simultaneous push and pop on a non-full FIFO leaves `ReqCount` unchanged.
  - Pointers wrap modulo DEPTH.
- **FSM states:** `IDLE`, `LOAD`, `GAP`, `RUN`.
- **`IDLE`:** acts only when the FIFO is non-empty and `RspValid = 0`. Otherwise it waits.
  - If the head `Dvsr == 0`: pop the head and write the response (`RspQ = 0xFFFFFFFF`, `RspR = Dvnd`, `RspDivZero = 1`). Stay in `IDLE`; the divider is untouched.
  - Otherwise: pop the head into the operand/tag registers and go to `LOAD`.
- **`LOAD`:** `DivRst = 1` for exactly one cycle, then go to `GAP`.
- **`GAP`:** `DivRst = 0`, `DivRun = 0` for one cycle, then go to `RUN`. Clear the timeout counter.
- **`RUN`:** `DivRun = 1` and the timeout counter increments.
  - Rdy-edge detect uses `rdy_d`, a registered copy of `DivRdy`.
  - If `DivRdy & ~rdy_d`: capture `DivQ`/`DivR` and the tag into the response registers, set `RspValid`, and go to `IDLE`.
  - Else if the counter equals `TIMEOUT - 1`: write a response with `RspQ = 0`, `RspR = 0`, `RspTimeout = 1`, and go to `IDLE`.
  - `DivRdy` is ignored in every other state.
- **Operand hold.** `DivDvnd`/`DivDvsr` are registered and held constant from `LOAD` until the next `LOAD`.
- **Response hold.** The response registers hold while `RspValid & ~RspReady`. `RspValid` clears on `RspValid & RspReady`.
- **Ordering.** Responses leave in request order. At most one operation is in flight.

## Timing
- **Reset values** (asynchronous, while `Rst` is high and on release):
  - `RspValid`, `RspQ`, `RspR`, `RspTag`, flags, `DivRun`, `DivDvnd`, `DivDvsr`, `Busy`, `ReqCount` are all 0. FSM is in `IDLE`. FIFO is empty.
  - `ReqReady` is 0 while `Rst` is high and 1 after release.
  - `DivRst = Rst | (state == LOAD)`, so the divider is held in reset during block reset.
- **Normal latency.** Let the request be accepted at edge E0.
  - Pop at E1.
  - `LOAD` (`DivRst` high) from E1 to E2.
  - `GAP` from E2 to E3.
  - `DivRun` high from E3.
  - If the `DivRdy` rising edge is sampled at edge En, `RspValid` is high after En and `DivRun` drops after En.
- **Divide-by-zero latency.** `RspValid` is high after E1.
- **Back-to-back requests.** The next request's `LOAD` begins no earlier than the cycle after its `RspValid` predecessor is consumed.
- **Timeout.** `RspValid` rises after the `TIMEOUT`-th `RUN` cycle edge.
- **Reset mid-operation.** `Rst` at any point aborts the in-flight operation, discards FIFO contents, and emits no response.

## Test plan
- 100/7, tag 1, `RspReady = 1` → `RspQ = 14`, `RspR = 2`, `RspTag = 1`, flags 0. `DivRst` is high for exactly one cycle; `DivRun` rises 2 cycles after `DivRst` rises.
- `Dvnd = 0x12345678`, `Dvsr = 0` → `RspValid` high 1 cycle after accept, `RspQ = 0xFFFFFFFF`, `RspR = 0x12345678`, `RspDivZero = 1`. `DivRst`/`DivRun` never assert.
- DEPTH = 4, `RspReady` held 0, 6 back-to-back requests → 5 accepted (1 popped, 4 queued). `ReqReady` is low on the 6th and `ReqCount = 4`. Releasing `RspReady` drains tags in order and `ReqReady` returns.
- Divider model never raises `Rdy`, `TIMEOUT = 16` → after 16 `RUN` cycles `RspTimeout = 1`, `RspQ = RspR = 0`. The next queued request then proceeds normally.
- `Rst` asserted mid-`RUN` with 2 queued → outputs go immediately to their reset values, `ReqCount = 0`, no response. After reset, request 0xFFFFFFFF/1 → `RspQ = 0xFFFFFFFF`, `RspR = 0`.
- `RspReady` low for 10 cycles after a result → `RspQ`/`RspR`/`RspTag` stay stable, FSM stays `IDLE` with a queued request, and `DivRst` stays 0 until the handshake completes.

Source files
------------

// File: rtl/div_request_sequencer.sv
// Queues divide requests and drives CompDivider through a Rst pulse, an idle gap, then Run until Rdy rises.
// Result 4 cycles + divider latency after accept; ReqReady drops when the queue is full, results hold until RspReady.

module div_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wr_dat,
    input  logic          pop,
    output logic [W-1:0]  rd_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module div_request_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     Rst,
    input  logic                     ReqValid,
    output logic                     ReqReady,
    input  logic [31:0]              ReqDvnd,
    input  logic [31:0]              ReqDvsr,
    input  logic [TAG_W-1:0]         ReqTag,
    output logic                     RspValid,
    input  logic                     RspReady,
    output logic [31:0]              RspQ,
    output logic [31:0]              RspR,
    output logic [TAG_W-1:0]         RspTag,
    output logic                     RspDivZero,
    output logic                     RspTimeout,
    output logic [31:0]              DivDvnd,
    output logic [31:0]              DivDvsr,
    output logic                     DivRun,
    output logic                     DivRst,
    input  logic [31:0]              DivQ,
    input  logic [31:0]              DivR,
    input  logic                     DivRdy,
    output logic                     Busy,
    output logic [$clog2(DEPTH):0]   ReqCount
);
    localparam int          CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef struct packed {
        logic [31:0]      dvnd;
        logic [31:0]      dvsr;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef enum logic [1:0] {IDLE, LOAD, GAP, RUN} state_t;

    state_t           state;
    req_t             req_wr_dat;
    req_t             head_dat;
    logic             fifo_full;
    logic             fifo_empty;
    logic             req_push;
    logic             head_pop;
    logic [CW-1:0]    run_cnt;
    logic             rdy_d;
    logic [TAG_W-1:0] tag_q;

    assign ReqReady   = ~fifo_full & ~Rst;
    assign req_push   = ReqValid & ReqReady;
    assign req_wr_dat = '{dvnd: ReqDvnd, dvsr: ReqDvsr, tag: ReqTag};
    assign head_pop   = (state == IDLE) & ~fifo_empty & ~RspValid;
    assign DivRst     = Rst | (state == LOAD);
    assign Busy       = (state != IDLE);

    div_req_fifo #(
        .W     ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk    (clk),
        .rst    (Rst),
        .push   (req_push),
        .wr_dat (req_wr_dat),
        .pop    (head_pop),
        .rd_dat (head_dat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (ReqCount)
    );

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            RspValid   <= 1'b0;
            RspQ       <= '0;
            RspR       <= '0;
            RspTag     <= '0;
            RspDivZero <= 1'b0;
            RspTimeout <= 1'b0;
            DivDvnd    <= '0;
            DivDvsr    <= '0;
            DivRun     <= 1'b0;
            run_cnt    <= '0;
            rdy_d      <= 1'b0;
            tag_q      <= '0;
        end else begin
            rdy_d <= DivRdy;
            if (RspValid & RspReady) begin
                RspValid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (head_pop) begin
                        if (head_dat.dvsr == '0) begin
                            // Divide-by-zero is answered here without touching the divider.
                            RspValid   <= 1'b1;
                            RspQ       <= '1;
                            RspR       <= head_dat.dvnd;
                            RspTag     <= head_dat.tag;
                            RspDivZero <= 1'b1;
                            RspTimeout <= 1'b0;
                        end else begin
                            DivDvnd <= head_dat.dvnd;
                            DivDvsr <= head_dat.dvsr;
                            tag_q   <= head_dat.tag;
                            state   <= LOAD;
                        end
                    end
                end
                LOAD: state <= GAP;
                GAP: begin
                    run_cnt <= '0;
                    DivRun  <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    run_cnt <= run_cnt + 1'b1;
                    if (DivRdy & ~rdy_d) begin
                        RspValid   <= 1'b1;
                        RspQ       <= DivQ;
                        RspR       <= DivR;
                        RspTag     <= tag_q;
                        RspDivZero <= 1'b0;
                        RspTimeout <= 1'b0;
                        DivRun     <= 1'b0;
                        state      <= IDLE;
                    end else if (run_cnt == TO_LAST) begin
                        RspValid   <= 1'b1;
                        RspQ       <= '0;
                        RspR       <= '0;
                        RspTag     <= tag_q;
                        RspDivZero <= 1'b0;
                        RspTimeout <= 1'b1;
                        DivRun     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
